// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and downstream memory port
// signals of mem_port_arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the CPU requesters plus the memory model.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // instruction fetch requester
   logic                  io_inst_reqValid;
   logic                  io_inst_reqReady;
   logic [ADDR_W-1:0]     io_inst_addr;
   logic                  io_inst_respValid;
   logic [DATA_W-1:0]     io_inst_readData;
   // data access requester
   logic                  io_data_reqValid;
   logic                  io_data_reqReady;
   logic                  io_data_writeEn;
   logic [ADDR_W-1:0]     io_data_addr;
   logic [DATA_W-1:0]     io_data_writeData;
   logic [DATA_W/8-1:0]   io_data_mark;
   logic                  io_data_respValid;
   logic [DATA_W-1:0]     io_data_readData;
   // downstream memory port
   logic                  mem_reqValid;
   logic                  mem_reqReady;
   logic                  mem_writeEn;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_writeData;
   logic [DATA_W/8-1:0]   mem_mark;
   logic                  mem_respValid;
   logic [DATA_W-1:0]     mem_readData;
   // status
   logic                  err_timeout;

   modport slave (
      input  io_inst_reqValid, io_inst_addr,
      input  io_data_reqValid, io_data_writeEn, io_data_addr, io_data_writeData, io_data_mark,
      input  mem_reqReady, mem_respValid, mem_readData,
      output io_inst_reqReady, io_inst_respValid, io_inst_readData,
      output io_data_reqReady, io_data_respValid, io_data_readData,
      output mem_reqValid, mem_writeEn, mem_addr, mem_writeData, mem_mark,
      output err_timeout
   );

   modport master (
      output io_inst_reqValid, io_inst_addr,
      output io_data_reqValid, io_data_writeEn, io_data_addr, io_data_writeData, io_data_mark,
      output mem_reqReady, mem_respValid, mem_readData,
      input  io_inst_reqReady, io_inst_respValid, io_inst_readData,
      input  io_data_reqReady, io_data_respValid, io_data_readData,
      input  mem_reqValid, mem_writeEn, mem_addr, mem_writeData, mem_mark,
      input  err_timeout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one valid/ready memory port between the instruction
// fetch and data requesters, one outstanding transaction at a time, with the
// response routed back to its owner and a watchdog that aborts hung accesses.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the data requester has fixed priority over instruction fetch.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic              clock,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned       CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [DATA_W-1:0] TO_WORD = DATA_W'(32'hDEADBEEF);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state_q, state_d;
   logic                owner_data_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] mark_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                err_q;

   logic                grant_data, grant_inst, accept;
   logic                busy, timeout_hit, resp_fire, abort, done;
   logic [DATA_W-1:0]   resp_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic                last_data_q;
`endif

   // Grant selection and transaction events; handshakes are masked during reset
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data = bus.io_data_reqValid && (!bus.io_inst_reqValid || !last_data_q);
`else
      grant_data = bus.io_data_reqValid;
`endif
      grant_inst  = bus.io_inst_reqValid && !grant_data;
      accept      = !reset && (state_q == IDLE) && (grant_data || grant_inst);
      busy        = (state_q != IDLE);
      timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == TO_LAST);
      resp_fire   = !reset && (state_q == WAIT) && bus.mem_respValid;
      // a real response in the same cycle as the watchdog limit takes precedence
      abort       = !reset && timeout_hit && !resp_fire;
      done        = resp_fire || abort;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE: begin
            if (abort)                 state_d = IDLE;
            else if (bus.mem_reqReady) state_d = WAIT;
         end
         WAIT:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch owner and payload on accept, run the watchdog, record aborts
   always_ff @(posedge clock) begin
      if (reset) begin
         owner_data_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mark_q       <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         if (accept) begin
            owner_data_q <= grant_data;
            cnt_q        <= '0;
            if (grant_data) begin
               we_q    <= bus.io_data_writeEn;
               addr_q  <= bus.io_data_addr;
               wdata_q <= bus.io_data_writeData;
               mark_q  <= bus.io_data_mark;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= bus.io_inst_addr;
               wdata_q <= '0;
               mark_q  <= '0;
            end
         end else if (busy) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (abort) err_q <= 1'b1;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember which side won the most recent accept
   always_ff @(posedge clock) begin
      if (reset)       last_data_q <= 1'b0;
      else if (accept) last_data_q <= grant_data;
   end
`endif

   // Handshake and response outputs
   always_comb begin
      bus.io_inst_reqReady  = 1'b0;
      bus.io_data_reqReady  = 1'b0;
      bus.io_inst_respValid = 1'b0;
      bus.io_data_respValid = 1'b0;
      bus.io_inst_readData  = '0;
      bus.io_data_readData  = '0;
      bus.mem_reqValid      = (state_q == ISSUE);
      if (abort)     resp_data = TO_WORD;
      else if (we_q) resp_data = '0;
      else           resp_data = bus.mem_readData;
      if (accept) begin
         bus.io_inst_reqReady = grant_inst;
         bus.io_data_reqReady = grant_data;
      end
      if (done) begin
         if (owner_data_q) begin
            bus.io_data_respValid = 1'b1;
            bus.io_data_readData  = resp_data;
         end else begin
            bus.io_inst_respValid = 1'b1;
            bus.io_inst_readData  = resp_data;
         end
      end
   end

   assign bus.mem_writeEn   = we_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_writeData = wdata_q;
   assign bus.mem_mark      = mark_q;
   assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter. A transaction
// level model predicts the grant, the downstream payload and the routed
// response; directed and randomized accesses are checked cycle by cycle.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit model_last_data = 1'b0;

   // Arbitration rule: single valid wins; both valid -> data (fixed) or the
   // side not granted last (round robin).
   function automatic bit model_pick_data(input bit iv, input bit dv);
      if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !model_last_data;
`else
         return 1'b1;
`endif
      end
      return dv;
   endfunction

   function automatic logic [4:0] flags();
      return {bus.io_inst_reqReady, bus.io_data_reqReady,
              bus.io_inst_respValid, bus.io_data_respValid, bus.mem_reqValid};
   endfunction

   function automatic logic [68:0] payload();
      return {bus.mem_writeEn, bus.mem_addr, bus.mem_writeData, bus.mem_mark};
   endfunction

   task automatic idle_inputs();
      bus.io_inst_reqValid  = 1'b0;
      bus.io_inst_addr      = '0;
      bus.io_data_reqValid  = 1'b0;
      bus.io_data_writeEn   = 1'b0;
      bus.io_data_addr      = '0;
      bus.io_data_writeData = '0;
      bus.io_data_mark      = '0;
      bus.mem_reqReady      = 1'b0;
      bus.mem_respValid     = 1'b0;
      bus.mem_readData      = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One complete access: IDLE accept, acc_dly stalled ISSUE cycles, ISSUE
   // accept, resp_dly WAIT cycles, response. hold keeps requests asserted.
   task automatic one_access(input bit iv, input bit dv, input bit we,
                             input logic [31:0] iaddr, input logic [31:0] daddr,
                             input logic [31:0] wdata, input logic [3:0] mark,
                             input int acc_dly, input int resp_dly,
                             input logic [31:0] rdata, input bit stray,
                             input bit hold, input string tag);
      bit          pick;
      logic [68:0] exp_pl;
      logic [31:0] exp_rd, got_rd;
      logic [4:0]  exp_f;
      pick   = model_pick_data(iv, dv);
      exp_pl = pick ? {we, daddr, wdata, mark} : {1'b0, iaddr, 32'h0, 4'h0};
      exp_rd = (pick && we) ? 32'h0 : rdata;

      bus.io_inst_reqValid  = iv;
      bus.io_inst_addr      = iaddr;
      bus.io_data_reqValid  = dv;
      bus.io_data_writeEn   = we;
      bus.io_data_addr      = daddr;
      bus.io_data_writeData = wdata;
      bus.io_data_mark      = mark;
      bus.mem_reqReady      = 1'($urandom_range(0, 1));
      bus.mem_respValid     = stray;
      bus.mem_readData      = $urandom;
      @(negedge clock);
      exp_f = {!pick, pick, 3'b000};
      checks++;
      if (flags() !== exp_f)
         $display("FAIL %s grant: got %b want %b", tag, flags(), exp_f);
      if (flags() !== exp_f) errors++;
      step();
      model_last_data = pick;

      if (!hold) begin
         bus.io_inst_reqValid  = 1'b0;
         bus.io_data_reqValid  = 1'b0;
         bus.io_inst_addr      = $urandom;
         bus.io_data_addr      = $urandom;
         bus.io_data_writeData = $urandom;
         bus.io_data_writeEn   = 1'($urandom_range(0, 1));
      end
      bus.mem_respValid = 1'b0;
      bus.mem_reqReady  = 1'b0;
      for (int i = 0; i < acc_dly; i++) begin
         @(negedge clock);
         checks++;
         if (flags() !== 5'b00001 || payload() !== exp_pl) begin
            errors++;
            $display("FAIL %s issue_stall%0d: got %b/%h want 00001/%h", tag, i, flags(), payload(), exp_pl);
         end
         step();
      end
      bus.mem_reqReady  = 1'b1;
      bus.mem_respValid = stray;
      @(negedge clock);
      checks++;
      if (flags() !== 5'b00001 || payload() !== exp_pl) begin
         errors++;
         $display("FAIL %s issue: got %b/%h want 00001/%h", tag, flags(), payload(), exp_pl);
      end
      step();

      bus.mem_reqReady  = 1'b0;
      bus.mem_respValid = 1'b0;
      for (int i = 0; i < resp_dly; i++) begin
         @(negedge clock);
         checks++;
         if (flags() !== 5'b00000) begin
            errors++;
            $display("FAIL %s wait%0d: got %b want 00000", tag, i, flags());
         end
         step();
      end
      bus.mem_respValid = 1'b1;
      bus.mem_readData  = rdata;
      @(negedge clock);
      exp_f  = {2'b00, !pick, pick, 1'b0};
      got_rd = pick ? bus.io_data_readData : bus.io_inst_readData;
      checks++;
      if (flags() !== exp_f || got_rd !== exp_rd) begin
         errors++;
         $display("FAIL %s resp: got %b/%h want %b/%h", tag, flags(), got_rd, exp_f, exp_rd);
      end
      step();
      bus.mem_respValid = 1'b0;
      if (!hold) idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      @(negedge clock);
      checks++;
      if (flags() !== 5'b00000 || payload() !== 69'h0 || bus.err_timeout !== 1'b0 ||
          bus.io_inst_readData !== 32'h0 || bus.io_data_readData !== 32'h0) begin
         errors++;
         $display("FAIL reset: got %b/%h/%b want 00000/0/0", flags(), payload(), bus.err_timeout);
      end
      reset = 1'b0;
      model_last_data = 1'b0;
      step();
   endtask

   task automatic test_inst_read();
      one_access(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0,
                 0, 0, 32'h0000_0413, 1'b0, 1'b0, "inst_read");
   endtask

   task automatic test_data_write();
      one_access(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 32'hA5A5_A5A5, 4'hF,
                 0, 0, 32'h1234_5678, 1'b0, 1'b0, "data_write");
   endtask

   task automatic test_stall();
      one_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2000, 32'h0, 4'h3,
                 5, 0, 32'hCAFE_F00D, 1'b1, 1'b0, "stall5");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         one_access(1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h8000_3000, 32'h0, 4'h0,
                    0, 0, 32'h1000 + k, 1'b0, 1'b1, "b2b");
      idle_inputs();
   endtask

   task automatic test_random();
      bit iv, dv;
      for (int k = 0; k < 24; k++) begin
         iv = 1'($urandom_range(0, 1));
         dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
         one_access(iv, dv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 1)), 1'b0, "random");
      end
   endtask

   // Hung memory: accepted (or never accepted) request with no response.
   task automatic timeout_run(input bit is_data, input bit mem_accepts, input string tag);
      int          n;
      bit          seen;
      logic [31:0] rd;
      bus.io_inst_reqValid = !is_data;
      bus.io_inst_addr     = 32'h8000_0040;
      bus.io_data_reqValid = is_data;
      bus.io_data_writeEn  = 1'b1;
      bus.io_data_addr     = 32'h8000_4000;
      step();
      model_last_data = is_data;
      idle_inputs();
      bus.mem_reqReady = mem_accepts;
      seen = 1'b0;
      n    = 0;
      rd   = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (bus.io_inst_respValid || bus.io_data_respValid) begin
            seen = 1'b1;
            n    = c;
            rd   = is_data ? bus.io_data_readData : bus.io_inst_readData;
            break;
         end
         step();
         bus.mem_reqReady = 1'b0;
      end
      checks++;
      if (!seen || n != TO) begin
         errors++;
         $display("FAIL %s latency: got seen=%0d cycle=%0d want cycle=%0d", tag, seen, n, TO);
      end
      checks++;
      if (rd !== 32'hDEADBEEF || (is_data ? bus.io_inst_respValid : bus.io_data_respValid) !== 1'b0) begin
         errors++;
         $display("FAIL %s data: got %h want deadbeef", tag, rd);
      end
      step();
      @(negedge clock);
      checks++;
      if (bus.err_timeout !== 1'b1 || flags() !== 5'b00000) begin
         errors++;
         $display("FAIL %s sticky: got err=%b flags=%b want 1/00000", tag, bus.err_timeout, flags());
      end
      step();
   endtask

   task automatic test_timeout();
      @(negedge clock);
      checks++;
      if (bus.err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pre: got %b want 0", bus.err_timeout);
      end
      step();
      timeout_run(1'b0, 1'b1, "timeout_wait");
      one_access(1'b1, 1'b0, 1'b0, 32'h8000_0080, 32'h0, 32'h0, 4'h0,
                 1, 2, 32'h0BAD_F00D, 1'b0, 1'b0, "after_timeout");
      timeout_run(1'b1, 1'b0, "timeout_issue");
   endtask

   task automatic test_reset_mid();
      bus.io_data_reqValid = 1'b1;
      bus.io_data_addr     = 32'h8000_5000;
      step();
      idle_inputs();
      bus.mem_reqReady = 1'b1;
      step();
      bus.mem_reqReady = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (flags() !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_hold: got %b want 00000", flags());
      end
      step();
      reset = 1'b0;
      model_last_data = 1'b0;
      bus.mem_respValid = 1'b1;
      bus.mem_readData  = 32'h5555_AAAA;
      @(negedge clock);
      checks++;
      if (flags() !== 5'b00000 || bus.err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_stray: got %b err=%b want 00000 err=0", flags(), bus.err_timeout);
      end
      step();
      idle_inputs();
      one_access(1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h8000_6000, 32'h0, 4'h0,
                 0, 1, 32'h7777_1111, 1'b0, 1'b0, "post_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "tb timeout");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_inst_read();
      test_data_write();
      test_back_to_back();
      test_stall();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
